// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared constants, types and helpers for the TRNG collector blocks
package trng_pkg;

  localparam int MAX_CHANNELS = 8;
  localparam int REP_CNT_W    = 8;

  typedef enum logic [1:0] {
    VN_IDLE       = 2'd0,
    VN_HAVE_FIRST = 2'd1
  } vn_state_e;

  // $clog2 that never returns 0, so a counter for a divide-by-1 still has a bit
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/trng_word_collector_if.sv
// rtl/trng_word_collector_if.sv - valid/ready word channel between collector and bus logic
interface trng_word_collector_if #(
  parameter int WORD_WIDTH = 32
);

  logic [WORD_WIDTH-1:0] rnd_data;
  logic                  rnd_valid;
  logic                  rnd_ready;

  modport master (
    output rnd_data,
    output rnd_valid,
    input  rnd_ready
  );

  modport slave (
    input  rnd_data,
    input  rnd_valid,
    output rnd_ready
  );

endinterface

// File: rtl/trng_sync2.sv
// rtl/trng_sync2.sv - two-flop synchroniser for oscillator-domain bits
module trng_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // first stage may go metastable; second stage gives it a cycle to settle
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // synchroniser flops, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/trng_word_collector.sv
// rtl/trng_word_collector.sv - samples ring oscillators, health-tests and packs bits into words (optional TRNG_VON_NEUMANN_EN debiasing)
module trng_word_collector
  import trng_pkg::*;
#(
  parameter int NUM_CHANNELS = 2,
  parameter int WORD_WIDTH   = 32,
  parameter int SAMPLE_DIV   = 4,
  parameter int REP_LIMIT    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    trng_en,
  output logic                    osc_en,
  input  logic [NUM_CHANNELS-1:0] osc_raw,
  trng_word_collector_if.master   rnd_if,
  output logic                    health_fail
);

  localparam int DIV_W = clog2_min1(SAMPLE_DIV);
  localparam int CNT_W = $clog2(WORD_WIDTH + 1);
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(WORD_WIDTH);
  localparam logic [REP_CNT_W-1:0] REP_LIM  = REP_CNT_W'(REP_LIMIT);
  localparam logic [REP_CNT_W-1:0] REP_MAX  = '1;

  logic [NUM_CHANNELS-1:0] sync_bits;
  logic [MAX_CHANNELS-1:0] sync_ext;
  logic                    sample;

  logic                  osc_en_q, osc_en_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [REP_CNT_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic                  prev_q, prev_d;
  logic                  health_fail_q, health_fail_d;
  logic                  valid_q, valid_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
`ifdef TRNG_VON_NEUMANN_EN
  vn_state_e             vn_state_q, vn_state_d;
  logic                  vn_first_q, vn_first_d;
`endif

  logic take, word_full, load, tick, drop, tested;
  logic accept, accept_bit;

  trng_sync2 #(.WIDTH(NUM_CHANNELS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (osc_raw),
    .q     (sync_bits)
  );

  // unused channel slots pad with zeros so they do not disturb the XOR
  assign sync_ext = MAX_CHANNELS'(sync_bits);
  assign sample   = ^sync_ext;

  // a full shift word moves out when the output register is free or being drained now;
  // ticks that find a full word with nowhere to go are dropped untested
  assign take      = valid_q & rnd_if.rnd_ready;
  assign word_full = (bit_cnt_q == CNT_FULL);
  assign load      = word_full & ~health_fail_q & (~valid_q | take);
  assign tick      = trng_en & (div_q == DIV_LAST);
  assign drop      = tick & word_full & ~load;
  assign tested    = tick & ~drop & ~health_fail_q;

  // next-state for divider, health test, debias, packing and output register
  always_comb begin
    osc_en_d      = trng_en;
    div_d         = div_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    rep_cnt_d     = rep_cnt_q;
    prev_d        = prev_q;
    health_fail_d = health_fail_q;
    valid_d       = valid_q;
    data_d        = data_q;
    accept        = 1'b0;
    accept_bit    = sample;
`ifdef TRNG_VON_NEUMANN_EN
    vn_state_d    = vn_state_q;
    vn_first_d    = vn_first_q;
`endif

    if (trng_en) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end

    // repetition count on the raw sample; rep_cnt of 0 means no previous sample yet
    if (tested) begin
      prev_d = sample;
      if ((rep_cnt_q == '0) || (sample != prev_q)) begin
        rep_cnt_d = REP_CNT_W'(1);
      end else if (rep_cnt_q != REP_MAX) begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
      if (rep_cnt_d >= REP_LIM) begin
        health_fail_d = 1'b1;
      end
    end

`ifdef TRNG_VON_NEUMANN_EN
    // pair samples: differing pair yields its first bit, equal pair is discarded
    if (health_fail_q || drop) begin
      vn_state_d = VN_IDLE;
    end else if (tested) begin
      if (vn_state_q == VN_IDLE) begin
        vn_state_d = VN_HAVE_FIRST;
        vn_first_d = sample;
      end else begin
        vn_state_d = VN_IDLE;
        accept     = (vn_first_q != sample);
        accept_bit = vn_first_q;
      end
    end
`else
    accept = tested;
`endif

    if (load) begin
      data_d    = shift_q;
      valid_d   = 1'b1;
      bit_cnt_d = '0;
    end else if (take) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      shift_d   = {shift_q[WORD_WIDTH-2:0], accept_bit};
      bit_cnt_d = load ? CNT_W'(1) : bit_cnt_q + 1'b1;
    end

    // a failed source must not leak a partially built word
    if (health_fail_q) begin
      shift_d   = '0;
      bit_cnt_d = '0;
    end

    // disable wipes everything, including a word not yet taken
    if (!trng_en) begin
      div_d         = '0;
      shift_d       = '0;
      bit_cnt_d     = '0;
      rep_cnt_d     = '0;
      prev_d        = 1'b0;
      health_fail_d = 1'b0;
      valid_d       = 1'b0;
      data_d        = '0;
`ifdef TRNG_VON_NEUMANN_EN
      vn_state_d    = VN_IDLE;
      vn_first_d    = 1'b0;
`endif
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      osc_en_q      <= 1'b0;
      div_q         <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      rep_cnt_q     <= '0;
      prev_q        <= 1'b0;
      health_fail_q <= 1'b0;
      valid_q       <= 1'b0;
      data_q        <= '0;
`ifdef TRNG_VON_NEUMANN_EN
      vn_state_q    <= VN_IDLE;
      vn_first_q    <= 1'b0;
`endif
    end else begin
      osc_en_q      <= osc_en_d;
      div_q         <= div_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      rep_cnt_q     <= rep_cnt_d;
      prev_q        <= prev_d;
      health_fail_q <= health_fail_d;
      valid_q       <= valid_d;
      data_q        <= data_d;
`ifdef TRNG_VON_NEUMANN_EN
      vn_state_q    <= vn_state_d;
      vn_first_q    <= vn_first_d;
`endif
    end
  end

  assign osc_en           = osc_en_q;
  assign health_fail      = health_fail_q;
  assign rnd_if.rnd_data  = data_q;
  assign rnd_if.rnd_valid = valid_q;

endmodule
